// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester channels and the shared data-memory port.
// slave: arbiter side; master: requesters plus memory (bench side).
interface dmem_arbiter_if #(
   parameter int DMEM_ADDR_W = 12,
   parameter int DMEM_DATA_W = 32
) ();
   logic                   r0_req;
   logic                   r0_lock;
   logic                   r0_we;
   logic [DMEM_ADDR_W-1:0] r0_addr;
   logic [DMEM_DATA_W-1:0] r0_wdata;
   logic                   r0_gnt;
   logic                   r0_rvalid;
   logic [DMEM_DATA_W-1:0] r0_rdata;
   logic                   r1_req;
   logic                   r1_lock;
   logic                   r1_we;
   logic [DMEM_ADDR_W-1:0] r1_addr;
   logic [DMEM_DATA_W-1:0] r1_wdata;
   logic                   r1_gnt;
   logic                   r1_rvalid;
   logic [DMEM_DATA_W-1:0] r1_rdata;
   logic                   dmem_wen;
   logic [DMEM_ADDR_W-1:0] dmem_waddr;
   logic [DMEM_DATA_W-1:0] dmem_wdata;
   logic                   dmem_ren;
   logic [DMEM_ADDR_W-1:0] dmem_raddr;
   logic [DMEM_DATA_W-1:0] dmem_rdata;

   modport slave (
      input  r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
      input  r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
      input  dmem_rdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output dmem_wen, dmem_waddr, dmem_wdata,
      output dmem_ren, dmem_raddr
   );

   modport master (
      output r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
      output r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
      output dmem_rdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  dmem_wen, dmem_waddr, dmem_wdata,
      input  dmem_ren, dmem_raddr
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data-memory port, with burst lock.
// Ports: clk, rst (async active-low), bus (dmem_arbiter_if.slave);
// DMEM_ARB_STATS_EN adds stat_gnt0/stat_gnt1/stat_conflict counters.
module dmem_arbiter #(
   parameter int DMEM_ADDR_W = 12,
   parameter int DMEM_DATA_W = 32,
   parameter int MAX_BURST   = 4
) (
   input  logic         clk,
   input  logic         rst,
   dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]  stat_gnt0,
   output logic [31:0]  stat_gnt1,
   output logic [31:0]  stat_conflict
`endif
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);
   localparam bit LOCK_EN = (MAX_BURST > 1);

   state_e     state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pend_q, pend_d;
   logic       id_q, id_d;

   logic       g0, g1, own0, own1;
   logic [7:0] cnt_inc;
   logic       we_s;
   logic [DMEM_ADDR_W-1:0] addr_s;
   logic [DMEM_DATA_W-1:0] wdata_s;

   always_comb begin
      g0      = 1'b0;
      g1      = 1'b0;
      state_d = IDLE;
      cnt_d   = 8'd0;
      cnt_inc = cnt_q + 8'd1;
      own0    = (state_q == OWN0) && bus.r0_req;
      own1    = (state_q == OWN1) && bus.r1_req;
      if (own0) begin
         g0 = 1'b1;
         if (bus.r0_lock && cnt_inc != MAX_B) begin
            state_d = OWN0;
            cnt_d   = cnt_inc;
         end
      end else if (own1) begin
         g1 = 1'b1;
         if (bus.r1_lock && cnt_inc != MAX_B) begin
            state_d = OWN1;
            cnt_d   = cnt_inc;
         end
      end else begin
         // last_q=1 means r1 won last, so r0 takes the conflict
         if (bus.r0_req && bus.r1_req) begin
            g0 = last_q;
            g1 = ~last_q;
         end else begin
            g0 = bus.r0_req;
            g1 = bus.r1_req;
         end
         if (LOCK_EN && g0 && bus.r0_lock) begin
            state_d = OWN0;
            cnt_d   = 8'd1;
         end else if (LOCK_EN && g1 && bus.r1_lock) begin
            state_d = OWN1;
            cnt_d   = 8'd1;
         end
      end
      if (!rst) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
      last_d = last_q;
      if (g0) last_d = 1'b0;
      else if (g1) last_d = 1'b1;
   end

   always_comb begin
      we_s    = g1 ? bus.r1_we    : bus.r0_we;
      addr_s  = g1 ? bus.r1_addr  : bus.r0_addr;
      wdata_s = g1 ? bus.r1_wdata : bus.r0_wdata;
      pend_d  = (g0 | g1) & ~we_s;
      id_d    = g1;
   end

   assign bus.r0_gnt     = g0;
   assign bus.r1_gnt     = g1;
   assign bus.dmem_wen   = (g0 | g1) & we_s;
   assign bus.dmem_ren   = pend_d;
   assign bus.dmem_waddr = bus.dmem_wen ? addr_s  : '0;
   assign bus.dmem_wdata = bus.dmem_wen ? wdata_s : '0;
   assign bus.dmem_raddr = bus.dmem_ren ? addr_s  : '0;

   assign bus.r0_rvalid = rst & pend_q & ~id_q;
   assign bus.r1_rvalid = rst & pend_q & id_q;
   assign bus.r0_rdata  = bus.r0_rvalid ? bus.dmem_rdata : '0;
   assign bus.r1_rdata  = bus.r1_rvalid ? bus.dmem_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
         pend_q  <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] sg0_q, sg1_q, sc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sg0_q <= '0;
         sg1_q <= '0;
         sc_q  <= '0;
      end else begin
         if (g0 && sg0_q != '1) sg0_q <= sg0_q + 32'd1;
         if (g1 && sg1_q != '1) sg1_q <= sg1_q + 32'd1;
         if (bus.r0_req && bus.r1_req && sc_q != '1)
            sc_q <= sc_q + 32'd1;
      end
   end

   assign stat_gnt0     = sg0_q;
   assign stat_gnt1     = sg1_q;
   assign stat_conflict = sc_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps plus random traffic,
// compared each cycle against a behavioural arbitration model.
module tb_dmem_arbiter;
   localparam int AW   = 12;
   localparam int DW   = 32;
   localparam int MAXB = 4;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   dmem_arbiter_if #(.DMEM_ADDR_W(AW), .DMEM_DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   dmem_arbiter #(
      .DMEM_ADDR_W(AW),
      .DMEM_DATA_W(DW),
      .MAX_BURST(MAXB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_gnt0(stat_gnt0),
      .stat_gnt1(stat_gnt1),
      .stat_conflict(stat_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state: current owner (-1 none), grants in the run, last winner
   int          m_own;
   int          m_streak;
   int          m_last;
   bit          m_pend;
   int          m_pid;
   logic [AW-1:0] m_paddr;

   function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
      return {a, 20'h0} ^ 32'h1357_9BDF ^ {20'h0, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own    = -1;
      m_streak = 0;
      m_last   = 1;
      m_pend   = 0;
      m_pid    = 0;
      m_paddr  = '0;
   endtask

   task automatic zero_inputs();
      bus.r0_req = 0; bus.r0_lock = 0; bus.r0_we = 0;
      bus.r0_addr = '0; bus.r0_wdata = '0;
      bus.r1_req = 0; bus.r1_lock = 0; bus.r1_we = 0;
      bus.r1_addr = '0; bus.r1_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      zero_inputs();
      bus.dmem_rdata = '0;
      #1;
      chk("rst_gnt0", 32'(bus.r0_gnt), 0);
      chk("rst_gnt1", 32'(bus.r1_gnt), 0);
      chk("rst_wen", 32'(bus.dmem_wen), 0);
      chk("rst_ren", 32'(bus.dmem_ren), 0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_rv0", 32'(bus.r0_rvalid), 0);
      chk("rst_rv1", 32'(bus.r1_rvalid), 0);
      model_reset();
      rst = 1'b1;
   endtask

   // One cycle: drive at negedge, check at +1, then step past posedge.
   // exp_w: -2 no order check, -1 expect no grant, 0/1 expected winner.
   // rst_mid: pull reset low after the checks, before the clock edge.
   task automatic cycle(
      input bit q0, input bit l0, input bit w0,
      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input bit q1, input bit l1, input bit w1,
      input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input int exp_w, input bit rst_mid);
      int win;
      bit [1:0] rq, lk;
      bit ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [AW-1:0] raddr_seen;
      bus.r0_req = q0; bus.r0_lock = l0; bus.r0_we = w0;
      bus.r0_addr = a0; bus.r0_wdata = d0;
      bus.r1_req = q1; bus.r1_lock = l1; bus.r1_we = w1;
      bus.r1_addr = a1; bus.r1_wdata = d1;
      #1;
      rq  = {q1, q0};
      lk  = {l1, l0};
      win = -1;
      if (m_own >= 0 && rq[m_own]) begin
         win = m_own;
         m_streak++;
         if (!lk[m_own] || m_streak == MAXB) begin
            m_own = -1;
            m_streak = 0;
         end
      end else begin
         m_own = -1;
         m_streak = 0;
         if (q0 && q1) win = 1 - m_last;
         else if (q0) win = 0;
         else if (q1) win = 1;
         if (win >= 0 && lk[win] && MAXB > 1) begin
            m_own = win;
            m_streak = 1;
         end
      end
      ew = (win == 1) ? w1 : w0;
      ea = (win == 1) ? a1 : a0;
      ed = (win == 1) ? d1 : d0;
      chk("gnt0", 32'(bus.r0_gnt), 32'(win == 0));
      chk("gnt1", 32'(bus.r1_gnt), 32'(win == 1));
      chk("wen", 32'(bus.dmem_wen), 32'(win >= 0 && ew));
      chk("ren", 32'(bus.dmem_ren), 32'(win >= 0 && !ew));
      chk("waddr", 32'(bus.dmem_waddr),
          (win >= 0 && ew) ? 32'(ea) : 0);
      chk("wdata", bus.dmem_wdata, (win >= 0 && ew) ? ed : 0);
      chk("raddr", 32'(bus.dmem_raddr),
          (win >= 0 && !ew) ? 32'(ea) : 0);
      chk("rv0", 32'(bus.r0_rvalid), 32'(m_pend && m_pid == 0));
      chk("rv1", 32'(bus.r1_rvalid), 32'(m_pend && m_pid == 1));
      chk("rd0", bus.r0_rdata,
          (m_pend && m_pid == 0) ? hash(m_paddr) : 0);
      chk("rd1", bus.r1_rdata,
          (m_pend && m_pid == 1) ? hash(m_paddr) : 0);
      if (exp_w != -2)
         chk("order", {30'd0, bus.r1_gnt, bus.r0_gnt},
             (exp_w < 0) ? 0 : (32'd1 << exp_w));
      raddr_seen = bus.dmem_raddr;
      if (win >= 0) m_last = win;
      m_pend  = (win >= 0) && !ew;
      m_pid   = win;
      m_paddr = ea;
      if (rst_mid) begin
         rst = 1'b0;
         #1;
         chk("mid_gnt0", 32'(bus.r0_gnt), 0);
         chk("mid_gnt1", 32'(bus.r1_gnt), 0);
         chk("mid_ren", 32'(bus.dmem_ren), 0);
      end
      @(posedge clk);
      bus.dmem_rdata = hash(raddr_seen);
      @(negedge clk);
      if (rst_mid) begin
         chk("mid_rv0", 32'(bus.r0_rvalid), 0);
         chk("mid_rv1", 32'(bus.r1_rvalid), 0);
         model_reset();
         rst = 1'b1;
      end
   endtask

   initial begin
      bit q0, q1, l0, l1, w0, w1;
      model_reset();
      do_reset();
      cycle(0,0,0,'0,'0, 0,0,0,'0,'0, -1, 0);
      cycle(1,0,1,12'd5,32'hDEAD_BEEF, 0,0,0,'0,'0, 0, 0);
      cycle(0,0,0,'0,'0, 0,0,0,'0,'0, -1, 0);

      do_reset();
      for (int i = 0; i < 4; i++)
         cycle(1,0,0,12'd1,'0, 1,0,0,12'd2,'0, i % 2, 0);
      cycle(0,0,0,'0,'0, 0,0,0,'0,'0, -1, 0);

      do_reset();
      cycle(0,0,0,'0,'0, 1,1,0,12'd9,'0, 1, 0);
      for (int i = 0; i < 3; i++)
         cycle(1,0,0,12'd3,'0, 1,1,0,12'd9,'0, 1, 0);
      cycle(1,0,0,12'd3,'0, 1,1,0,12'd9,'0, 0, 0);

      do_reset();
      cycle(1,1,1,12'd4,32'h11,  0,0,0,'0,'0, 0, 0);
      cycle(1,1,1,12'd4,32'h22,  1,0,1,12'd8,32'h33, 0, 0);
      cycle(0,0,0,'0,'0,         1,0,1,12'd8,32'h44, 1, 0);
      cycle(1,0,0,12'd4,'0,      1,0,0,12'd8,'0, 0, 0);

      do_reset();
      cycle(0,0,0,'0,'0, 1,0,0,12'd7,'0, 1, 1);
      cycle(1,0,0,12'd6,'0, 1,0,0,12'd7,'0, 0, 0);
      cycle(0,0,0,'0,'0, 0,0,0,'0,'0, -1, 0);

      l0 = 0;
      l1 = 0;
      for (int i = 0; i < 300; i++) begin
         q0 = ($urandom_range(0, 3) != 0);
         q1 = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) l0 = ~l0;
         if ($urandom_range(0, 5) == 0) l1 = ~l1;
         w0 = $urandom_range(0, 1) == 1;
         w1 = $urandom_range(0, 1) == 1;
         cycle(q0, l0, w0, AW'($urandom_range(0, 4095)), $urandom,
               q1, l1, w1, AW'($urandom_range(0, 4095)), $urandom,
               -2, 0);
      end

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      for (int i = 0; i < 10; i++)
         cycle(1,0,0,12'd1,'0, 1,0,0,12'd2,'0, i % 2, 0);
      chk("stat_gnt0", stat_gnt0, 32'd5);
      chk("stat_gnt1", stat_gnt1, 32'd5);
      chk("stat_conflict", stat_conflict, 32'd10);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
